// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory, redirect and decode-side handshake bundle for fetch_ctrl.
interface fetch_ctrl_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_o_valid;
    logic        fetch_o_ready;
    logic [31:0] fetch_o_instr;
    logic [63:0] fetch_o_pc;
    logic [63:0] fetch_o_pre_pc;
    logic        fetch_o_commit;
    logic [63:0] fetch_o_fetch_cnt;
    logic [63:0] fetch_o_drop_cnt;
    modport master (
        output imem_req_valid, imem_req_addr, fetch_o_valid, fetch_o_instr, fetch_o_pc,
               fetch_o_pre_pc, fetch_o_commit, fetch_o_fetch_cnt, fetch_o_drop_cnt,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               fetch_o_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, fetch_o_valid, fetch_o_instr, fetch_o_pc,
               fetch_o_pre_pc, fetch_o_commit, fetch_o_fetch_cnt, fetch_o_drop_cnt,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               fetch_o_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer with redirect squashing and not-taken prediction.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input logic         clk,
    input logic         rst,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
    state_t      state;
    logic [63:0] pc;
    logic        drop;
    assign bus.imem_req_valid = ~rst & (state == REQ) & ~bus.redirect_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.fetch_o_commit = ~rst & bus.fetch_o_valid & bus.fetch_o_ready & ~bus.redirect_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= REQ;
            pc                    <= RESET_PC;
            drop                  <= 1'b0;
            bus.fetch_o_valid     <= 1'b0;
            bus.fetch_o_instr     <= '0;
            bus.fetch_o_pc        <= '0;
            bus.fetch_o_pre_pc    <= '0;
            bus.fetch_o_fetch_cnt <= '0;
            bus.fetch_o_drop_cnt  <= '0;
        end else if (bus.redirect_valid) begin
            pc <= {bus.redirect_pc[63:2], 2'b00};
            case (state)
                WAIT: begin
                    // a response in this very cycle is the outstanding one, so nothing is left to squash
                    if (bus.imem_resp_valid) begin
                        drop                 <= 1'b0;
                        bus.fetch_o_drop_cnt <= bus.fetch_o_drop_cnt + 64'd1;
                        state                <= REQ;
                    end else begin
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    bus.fetch_o_valid <= 1'b0;
                    state             <= REQ;
                end
                default: ;
            endcase
        end else begin
            case (state)
                REQ: state <= bus.imem_req_ready ? WAIT : REQ;
                WAIT: begin
                    if (bus.imem_resp_valid && drop) begin
                        drop                 <= 1'b0;
                        bus.fetch_o_drop_cnt <= bus.fetch_o_drop_cnt + 64'd1;
                        state                <= REQ;
                    end else if (bus.imem_resp_valid) begin
                        bus.fetch_o_instr  <= bus.imem_resp_data;
                        bus.fetch_o_pc     <= pc;
                        bus.fetch_o_pre_pc <= pc + 64'd4;
                        bus.fetch_o_valid  <= 1'b1;
                        state              <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.fetch_o_ready) begin
                        pc                    <= pc + 64'd4;
                        bus.fetch_o_valid     <= 1'b0;
                        bus.fetch_o_fetch_cnt <= bus.fetch_o_fetch_cnt + 64'd1;
                        state                 <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: random memory latency, backpressure, redirects and stray responses against a transaction-level model.
module tb_fetch_ctrl;
    localparam logic [63:0] RPC  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] WRPC = 64'hFFFF_FFFF_FFFF_FFFC;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    fetch_ctrl_if bus ();
    fetch_ctrl_if wb ();
    fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    fetch_ctrl #(.RESET_PC(WRPC)) dut_w (.clk(clk), .rst(rst), .bus(wb));
    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A3C_96E1;
    endfunction
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // model: next fetch address, whether a request is in flight, whether its answer is already stale, whether decode holds a word
    logic [63:0] m_pc, m_ipc, m_pre, m_fc, m_dc;
    logic [31:0] m_instr;
    logic        m_inflight, m_squash, m_hold;
    logic        mem_busy, mem_real, w_pend, w_seen;
    int          mem_lat, w_nreq;
    logic [63:0] mem_addr, w_addr;
    logic        e_req, e_commit;
    task automatic model_reset();
        m_pc = RPC; m_ipc = '0; m_pre = '0; m_instr = '0; m_fc = '0; m_dc = '0;
        m_inflight = 1'b0; m_squash = 1'b0; m_hold = 1'b0;
    endtask
    initial begin
        model_reset();
        mem_busy = 1'b0; mem_lat = 0; mem_addr = '0; w_pend = 1'b0; w_addr = '0;
        w_seen = 1'b0; w_nreq = 0;
        bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.fetch_o_ready = 1'b0;
        wb.imem_req_ready = 1'b1; wb.imem_resp_valid = 1'b0; wb.imem_resp_data = '0;
        wb.redirect_valid = 1'b0; wb.redirect_pc = '0; wb.fetch_o_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst = (i < 3) || (i >= 1500 && i < 1502);
            bus.redirect_valid = ($urandom_range(0, 9) == 0);
            bus.redirect_pc    = {$urandom, $urandom};
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.fetch_o_ready  = ($urandom_range(0, 9) < 7);
            mem_real = mem_busy && mem_lat == 0;
            bus.imem_resp_valid = mem_real || (!mem_busy && $urandom_range(0, 15) == 0);
            bus.imem_resp_data  = mem_real ? word_at(mem_addr) : $urandom;
            wb.imem_resp_valid = w_pend;
            wb.imem_resp_data  = word_at(w_addr);
            #3;
            e_req    = !rst && !m_inflight && !m_hold && !bus.redirect_valid;
            e_commit = !rst && m_hold && bus.fetch_o_ready && !bus.redirect_valid;
            check("req_valid", 64'(bus.imem_req_valid), 64'(e_req));
            check("req_addr", bus.imem_req_addr, m_pc);
            check("o_valid", 64'(bus.fetch_o_valid), 64'(m_hold));
            check("o_instr", 64'(bus.fetch_o_instr), 64'(m_instr));
            check("o_pc", bus.fetch_o_pc, m_ipc);
            check("o_pre_pc", bus.fetch_o_pre_pc, m_pre);
            check("commit", 64'(bus.fetch_o_commit), 64'(e_commit));
            check("fetch_cnt", bus.fetch_o_fetch_cnt, m_fc);
            check("drop_cnt", bus.fetch_o_drop_cnt, m_dc);
            if (!rst && wb.fetch_o_valid && !w_seen) begin
                w_seen = 1'b1;
                check("wrap_o_pc", wb.fetch_o_pc, WRPC);
                check("wrap_pre_pc", wb.fetch_o_pre_pc, 64'd0);
                check("wrap_instr", 64'(wb.fetch_o_instr), 64'(word_at(WRPC)));
            end
            if (!rst && wb.imem_req_valid && w_nreq < 2) begin
                w_nreq++;
                check("wrap_req_addr", wb.imem_req_addr, (w_nreq == 1) ? WRPC : 64'd0);
            end
            w_pend = !rst && wb.imem_req_valid;
            w_addr = wb.imem_req_addr;
            if (rst) begin
                mem_busy = 1'b0;
            end else begin
                if (mem_real) mem_busy = 1'b0;
                else if (mem_busy) mem_lat--;
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    mem_busy = 1'b1;
                    mem_lat  = $urandom_range(0, 3);
                    mem_addr = bus.imem_req_addr;
                end
            end
            if (rst) begin
                model_reset();
            end else if (bus.redirect_valid) begin
                m_pc   = bus.redirect_pc & ~64'd3;
                m_hold = 1'b0;
                if (m_inflight && bus.imem_resp_valid) begin
                    m_inflight = 1'b0; m_squash = 1'b0; m_dc = m_dc + 1;
                end else if (m_inflight) begin
                    m_squash = 1'b1;
                end
            end else if (e_req && bus.imem_req_ready) begin
                m_inflight = 1'b1;
            end else if (m_inflight && bus.imem_resp_valid) begin
                m_inflight = 1'b0;
                if (m_squash) begin
                    m_squash = 1'b0; m_dc = m_dc + 1;
                end else begin
                    m_hold = 1'b1; m_instr = word_at(m_pc); m_ipc = m_pc; m_pre = m_pc + 64'd4;
                end
            end else if (e_commit) begin
                m_hold = 1'b0; m_pc = m_pc + 64'd4; m_fc = m_fc + 1;
            end
        end
        check("wrap_seen", {62'd0, w_seen, w_nreq == 2}, 64'd3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
